// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute control unit and flag register for the 16-bit CPU.
// All strobes are Moore-decoded from the registered state and held at zero while reset is low.
module cpu_control_fsm #(
    parameter logic [6:0] OPC_LOAD  = 7'd8,
    parameter logic [6:0] OPC_STORE = 7'd9,
    parameter logic [6:0] OPC_BZ    = 7'd16,
    parameter logic [6:0] OPC_HALT  = 7'd127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opc,
    input  logic [2:0] opd1,
    input  logic [2:0] opd2,
    input  logic [2:0] opd3,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_s,
    input  logic       alu_z,
    output logic       ld_pc,
    output logic       ld_ir,
    output logic       ld_mar,
    output logic       rd_mem,
    output logic       wr_mem,
    output logic       ld_mdr_z,
    output logic       ld_mdr_data,
    output logic       wr_reg,
    output logic       rd_reg,
    output logic       ld_alu,
    output logic [4:0] ld_x,
    output logic [4:0] ld_y,
    output logic [2:0] wr_rega,
    output logic [2:0] rd_rega,
    output logic [2:0] fsel,
    output logic [4:0] state,
    output logic [3:0] flags,
    output logic       illegal,
    output logic       halted
);
    localparam logic [4:0] S_FETCH0 = 5'd0;
    localparam logic [4:0] S_FETCH1 = 5'd1;
    localparam logic [4:0] S_FETCH2 = 5'd2;
    localparam logic [4:0] S_DECODE = 5'd3;
    localparam logic [4:0] S_EX0    = 5'd4;
    localparam logic [4:0] S_EX1    = 5'd5;
    localparam logic [4:0] S_LD0    = 5'd6;
    localparam logic [4:0] S_LD1    = 5'd7;
    localparam logic [4:0] S_LD2    = 5'd8;
    localparam logic [4:0] S_LD3    = 5'd9;
    localparam logic [4:0] S_ST0    = 5'd10;
    localparam logic [4:0] S_ST1    = 5'd11;
    localparam logic [4:0] S_ST2    = 5'd12;
    localparam logic [4:0] S_BR0    = 5'd13;
    localparam logic [4:0] S_HALT   = 5'd31;
    localparam logic [4:0] X_PC     = 5'b00001;
    localparam logic [4:0] X_REG    = 5'b00100;
    localparam logic [4:0] X_MDR    = 5'b01000;
    localparam logic [4:0] X_CONST2 = 5'b10000;
    localparam logic [2:0] F_PASSX  = 3'b110;

    logic [4:0] next_state;
    logic       supported;

    assign supported = opc <= 7'd4 || opc == OPC_LOAD || opc == OPC_STORE || opc == OPC_BZ || opc == OPC_HALT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH0;
            flags <= 4'd0;
        end else begin
            state <= next_state;
            if (state == S_EX1)
                flags <= {alu_c, alu_v, alu_s, alu_z};
        end
    end

    always_comb begin
        next_state = S_FETCH0;
        case (state)
            S_FETCH0: next_state = S_FETCH1;
            S_FETCH1: next_state = S_FETCH2;
            S_FETCH2: next_state = S_DECODE;
            S_DECODE: next_state = opc <= 7'd4      ? S_EX0 :
                                   opc == OPC_LOAD  ? S_LD0 :
                                   opc == OPC_STORE ? S_ST0 :
                                   opc == OPC_BZ    ? S_BR0 :
                                   opc == OPC_HALT  ? S_HALT : S_FETCH0;
            S_EX0:    next_state = S_EX1;
            S_LD0:    next_state = S_LD1;
            S_LD1:    next_state = S_LD2;
            S_LD2:    next_state = S_LD3;
            S_ST0:    next_state = S_ST1;
            S_ST1:    next_state = S_ST2;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH0;
        endcase
    end

    // Everything defaults to zero; the case only runs once reset is released.
    always_comb begin
        ld_pc       = 1'b0;
        ld_ir       = 1'b0;
        ld_mar      = 1'b0;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        ld_mdr_z    = 1'b0;
        ld_mdr_data = 1'b0;
        wr_reg      = 1'b0;
        rd_reg      = 1'b0;
        ld_alu      = 1'b0;
        ld_x        = 5'd0;
        ld_y        = 5'd0;
        wr_rega     = 3'd0;
        rd_rega     = 3'd0;
        fsel        = 3'd0;
        illegal     = 1'b0;
        halted      = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH0: begin
                    ld_x   = X_PC;
                    fsel   = F_PASSX;
                    ld_alu = 1'b1;
                    ld_mar = 1'b1;
                end
                S_FETCH1: begin
                    rd_mem = 1'b1;
                    ld_y   = X_PC;
                end
                S_FETCH2: begin
                    ld_ir  = 1'b1;
                    ld_x   = X_CONST2;
                    ld_alu = 1'b1;
                    ld_pc  = 1'b1;
                end
                S_DECODE: illegal = !supported;
                S_EX0: begin
                    rd_reg  = 1'b1;
                    rd_rega = opd3;
                    ld_y    = X_REG;
                end
                S_EX1: begin
                    rd_reg  = 1'b1;
                    rd_rega = opd2;
                    ld_x    = X_REG;
                    fsel    = opc[2:0];
                    ld_alu  = 1'b1;
                    wr_reg  = 1'b1;
                    wr_rega = opd1;
                end
                S_LD0, S_ST0: begin
                    rd_reg  = 1'b1;
                    rd_rega = opd2;
                    ld_x    = X_REG;
                    fsel    = F_PASSX;
                    ld_alu  = 1'b1;
                    ld_mar  = 1'b1;
                end
                S_LD1: rd_mem = 1'b1;
                S_LD2: ld_mdr_data = 1'b1;
                S_LD3: begin
                    ld_x    = X_MDR;
                    fsel    = F_PASSX;
                    ld_alu  = 1'b1;
                    wr_reg  = 1'b1;
                    wr_rega = opd1;
                end
                S_ST1: begin
                    rd_reg   = 1'b1;
                    rd_rega  = opd1;
                    ld_x     = X_REG;
                    fsel     = F_PASSX;
                    ld_alu   = 1'b1;
                    ld_mdr_z = 1'b1;
                end
                S_ST2: wr_mem = 1'b1;
                S_BR0: if (flags[0]) begin
                    rd_reg  = 1'b1;
                    rd_rega = opd1;
                    ld_x    = X_REG;
                    fsel    = F_PASSX;
                    ld_alu  = 1'b1;
                    ld_pc   = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed plus randomized instruction stream against a per-instruction
// state-sequence and strobe model of the control unit.
module tb_cpu_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opc = 7'd0;
    logic [2:0] opd1 = 3'd0, opd2 = 3'd0, opd3 = 3'd0;
    logic       alu_c = 1'b0, alu_v = 1'b0, alu_s = 1'b0, alu_z = 1'b0;
    logic       ld_pc, ld_ir, ld_mar, rd_mem, wr_mem, ld_mdr_z, ld_mdr_data, wr_reg, rd_reg, ld_alu;
    logic [4:0] ld_x, ld_y, state;
    logic [2:0] wr_rega, rd_rega, fsel;
    logic [3:0] flags;
    logic       illegal, halted;
    logic [30:0] dout;

    int total = 0;
    int bad = 0;
    logic [3:0] mflags = 4'd0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .opc(opc), .opd1(opd1), .opd2(opd2), .opd3(opd3),
        .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s), .alu_z(alu_z),
        .ld_pc(ld_pc), .ld_ir(ld_ir), .ld_mar(ld_mar), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .ld_mdr_z(ld_mdr_z), .ld_mdr_data(ld_mdr_data), .wr_reg(wr_reg), .rd_reg(rd_reg),
        .ld_alu(ld_alu), .ld_x(ld_x), .ld_y(ld_y), .wr_rega(wr_rega), .rd_rega(rd_rega),
        .fsel(fsel), .state(state), .flags(flags), .illegal(illegal), .halted(halted)
    );

    assign dout = {ld_pc, ld_ir, ld_mar, rd_mem, wr_mem, ld_mdr_z, ld_mdr_data, wr_reg, rd_reg,
                   ld_alu, ld_x, ld_y, wr_rega, rd_rega, fsel, illegal, halted};

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe table of each named step, in the same bit order as dout.
    function automatic logic [30:0] expo(input int s, input logic [6:0] o, input logic [2:0] a, b, c, input logic z);
        logic lpc = 0, lir = 0, lmar = 0, rm = 0, wm = 0, lmz = 0, lmd = 0, wr = 0, rr = 0, la = 0, il = 0, h = 0;
        logic [4:0] x = 0, y = 0;
        logic [2:0] wa = 0, ra = 0, f = 0;
        case (s)
            0: begin x = 5'b00001; f = 3'b110; la = 1; lmar = 1; end
            1: begin rm = 1; y = 5'b00001; end
            2: begin lir = 1; x = 5'b10000; la = 1; lpc = 1; end
            3: il = !(o < 5 || o == 8 || o == 9 || o == 16 || o == 127);
            4: begin rr = 1; ra = c; y = 5'b00100; end
            5: begin rr = 1; ra = b; x = 5'b00100; f = o[2:0]; la = 1; wr = 1; wa = a; end
            6, 10: begin ra = b; rr = 1; x = 5'b00100; f = 3'b110; la = 1; lmar = 1; end
            7: rm = 1;
            8: lmd = 1;
            9: begin x = 5'b01000; f = 3'b110; la = 1; wr = 1; wa = a; end
            11: begin ra = a; rr = 1; x = 5'b00100; f = 3'b110; la = 1; lmz = 1; end
            12: wm = 1;
            13: if (z) begin ra = a; rr = 1; x = 5'b00100; f = 3'b110; la = 1; lpc = 1; end
            31: h = 1;
            default: ;
        endcase
        return {lpc, lir, lmar, rm, wm, lmz, lmd, wr, rr, la, x, y, wa, ra, f, il, h};
    endfunction

    task automatic run(input logic [6:0] o, input logic [2:0] a, b, c, input bit rnd, input logic [3:0] fl);
        int seq[$];
        seq = '{0, 1, 2, 3};
        if (o < 5) begin seq.push_back(4); seq.push_back(5); end
        else if (o == 8) begin seq.push_back(6); seq.push_back(7); seq.push_back(8); seq.push_back(9); end
        else if (o == 9) begin seq.push_back(10); seq.push_back(11); seq.push_back(12); end
        else if (o == 16) seq.push_back(13);
        else if (o == 127) seq.push_back(31);
        opc = o; opd1 = a; opd2 = b; opd3 = c;
        foreach (seq[i]) begin
            @(negedge clk);
            chk($sformatf("state[%0d] opc=%0d", i, o), 32'(state), 32'(seq[i]));
            chk($sformatf("outs@%0d opc=%0d", seq[i], o), 32'(dout), 32'(expo(seq[i], o, a, b, c, mflags[0])));
            chk("flags", 32'(flags), 32'(mflags));
            chk("rd_wr_mem_overlap", 32'(rd_mem & wr_mem), 32'd0);
            {alu_c, alu_v, alu_s, alu_z} = rnd ? 4'($urandom) : fl;
            @(posedge clk); #1;
            if (seq[i] == 5) mflags = {alu_c, alu_v, alu_s, alu_z};
        end
    endtask

    task automatic reset_check(input string tag);
        #1 reset = 1'b0;
        #1;
        mflags = 4'd0;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_flags"}, 32'(flags), 32'd0);
        chk({tag, "_outs"}, 32'(dout), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_flags", 32'(flags), 32'd0);
            chk("rst_outs", 32'(dout), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        run(7'd0, 3'd1, 3'd2, 3'd3, 1, 4'd0);
        run(7'd1, 3'd2, 3'd3, 3'd4, 0, 4'b1001);
        chk("sub_flags", 32'(flags), 32'h9);
        run(7'd16, 3'd6, 3'd1, 3'd2, 1, 4'd0);
        run(7'd8, 3'd4, 3'd5, 3'd0, 1, 4'd0);
        run(7'd9, 3'd3, 3'd7, 3'd1, 1, 4'd0);
        run(7'd2, 3'd5, 3'd5, 3'd5, 0, 4'b0110);
        run(7'd16, 3'd2, 3'd0, 3'd0, 1, 4'd0);
        run(7'd50, 3'd1, 3'd1, 3'd1, 1, 4'd0);
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [6:0] o;
            r = $urandom_range(0, 5);
            o = r == 0 ? 7'($urandom_range(0, 4)) : r == 1 ? 7'd8 : r == 2 ? 7'd9 : r == 3 ? 7'd16 :
                r == 4 ? 7'($urandom_range(17, 126)) : 7'($urandom_range(10, 15));
            run(o, 3'($urandom), 3'($urandom), 3'($urandom), 1, 4'd0);
        end
        opc = 7'd8; opd1 = 3'd4; opd2 = 3'd5;
        for (int k = 0; k < 12 && state != 5'd8; k++) begin
            @(posedge clk); #1;
        end
        chk("reach_ld2", 32'(state), 32'd8);
        reset_check("mid_ld2");
        run(7'd3, 3'd7, 3'd6, 3'd5, 1, 4'd0);
        run(7'd127, 3'd0, 3'd0, 3'd0, 1, 4'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_state", 32'(state), 32'd31);
            chk("halted", 32'(halted), 32'd1);
            @(posedge clk); #1;
        end
        reset_check("halt_rst");
        run(7'd0, 3'd1, 3'd2, 3'd3, 1, 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU, sitting directly upstream of the CPU datapath. It decodes the instruction register fields, runs the fetch/decode/execute state machine and drives every datapath load, read and write strobe. It also holds the architectural flag register (C,V,S,Z) captured from the ALU. Outputs are Moore-decoded from the registered state; the branch and dispatch decisions use the registered opcode and flags.

Parameters:
OPC_LOAD, 7'd8, opcode of LOAD rd=opd1, addr=reg[opd2]
OPC_STORE, 7'd9, opcode of STORE mem[reg[opd2]]=reg[opd1]
OPC_BZ, 7'd16, opcode of branch-if-zero PC=reg[opd1]
OPC_HALT, 7'd127, opcode of HALT

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low
opc  in  7  IR[15:9]
opd1  in  3  IR[8:6]
opd2  in  3  IR[5:3]
opd3  in  3  IR[2:0]
alu_c, alu_v, alu_s, alu_z  in  1 each  live ALU flag outputs
ld_pc, ld_ir, ld_mar, rd_mem, wr_mem, ld_mdr_z, ld_mdr_data, wr_reg, rd_reg, ld_alu  out  1 each  datapath strobes
ld_x  out  5  one-hot X-bus source {const2,mdr,reg,tmp,pc} (bit0=pc)
ld_y  out  5  one-hot Y-latch load source, same bit order
wr_rega, rd_rega  out  3 each  register-bank write/read address
fsel  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 negate, 110 pass X, 111 pass Y
state  out  5  current state code
flags  out  4  registered {C,V,S,Z}
illegal  out  1  high during DECODE when opc is unsupported
halted  out  1  high in HALT

Behaviour:
- Reset (reset=0, async): state=FETCH0 (0), flags=0, all strobes, ld_x, ld_y, fsel, addresses, illegal, halted forced 0 while reset low. The first rising edge after release executes FETCH0.
- The datapath Y latch and all datapath registers load on the same rising edge that ends the state.
- States and codes:
  - FETCH0 (0): ld_x=pc, fsel=110, ld_alu, ld_mar. Next state FETCH1.
  - FETCH1 (1): rd_mem, ld_y=pc. Next state FETCH2.
  - FETCH2 (2): ld_ir, ld_x=const2, fsel=000, ld_alu, ld_pc (PC+=2). Next state DECODE.
  - DECODE (3): no strobes. Dispatch on opc:
    - 0..4 -> EX0
    - OPC_LOAD -> LD0
    - OPC_STORE -> ST0
    - OPC_BZ -> BR0
    - OPC_HALT -> HALT
    - any other opc -> FETCH0 with illegal=1 for this one cycle (treated as NOP).
  - EX0 (4): rd_reg, rd_rega=opd3, ld_y=reg. Next state EX1.
  - EX1 (5): rd_reg, rd_rega=opd2, ld_x=reg, fsel=opc[2:0], ld_alu, wr_reg, wr_rega=opd1. Flags load alu_{c,v,s,z} on this edge only. Next state FETCH0.
  - LD0 (6): rd_rega=opd2, rd_reg, ld_x=reg, fsel=110, ld_alu, ld_mar. Next state LD1.
  - LD1 (7): rd_mem. Next state LD2.
  - LD2 (8): ld_mdr_data. Next state LD3.
  - LD3 (9): ld_x=mdr, fsel=110, ld_alu, wr_reg, wr_rega=opd1. Next state FETCH0.
  - ST0 (10): as LD0. Next state ST1.
  - ST1 (11): rd_rega=opd1, rd_reg, ld_x=reg, fsel=110, ld_alu, ld_mdr_z. Next state ST2.
  - ST2 (12): wr_mem. Next state FETCH0.
  - BR0 (13): if flags.Z=1: rd_rega=opd1, rd_reg, ld_x=reg, fsel=110, ld_alu, ld_pc. Else no strobes. Next state FETCH0.
  - HALT (31): halted=1, no strobes. Stays in HALT until reset.
- Output values:
  - At most one ld_x bit and one ld_y bit may be set in any state.
  - fsel=000 and both address outputs = 0 whenever unused.
  - wr_mem and rd_mem are never high in the same state.
- Flags change only in EX1. LOAD, STORE and BZ leave flags unchanged.
- Reset asserted mid-instruction: state returns immediately to FETCH0 and flags clear. Any partial instruction is abandoned.
- Unused state codes (14..30): next state FETCH0, no strobes.
- Instruction latency in cycles, including fetch:
  - ALU op: 6
  - LOAD: 8
  - STORE: 7
  - BZ: 5
  - Illegal opcode: 4

Test Plan:
- Reset, then release with opc=0 (ADD r1=r2+r3) -> states 0,1,2,3,4,5,0. In state 5: fsel=000, wr_rega=1, rd_rega=2, ld_x=00100. ld_pc high only in state 2.
- SUB opc=1 with alu_z=1, alu_c=1 presented in EX1 -> flags=4'b1001 after the EX1 edge; flags hold through the following fetch.
- LOAD opc=8, opd1=4, opd2=5 -> states 0,1,2,3,6,7,8,9,0. In state 6: ld_mar=1, rd_rega=5. In state 9: wr_reg=1, wr_rega=4, ld_x=01000.
- STORE opc=9 -> ld_mdr_z in state 11 and wr_mem in state 12, each for exactly one cycle; rd_mem never coincides with wr_mem.
- BZ opc=16 with flags.Z=0 -> no ld_pc in state 13. Repeat with Z=1 -> ld_pc=1, rd_rega=opd1, fsel=110.
- opc=50 -> illegal pulses one cycle in state 3, then state 0. opc=127 -> state 31 with halted=1 held for 20 cycles. Asserting reset low mid-LD2 -> state=0, flags=0, all strobes 0 asynchronously.
